// File: rtl/motor_arm_controller_pkg.sv
// Shared definitions for the motor arming sequencer.
//   - state encodings of the arming machine
//   - rate width, the zero rate constant, and default throttle thresholds
package motor_arm_controller_pkg;

  localparam int RATE_W = 16;

  localparam logic [RATE_W-1:0] RATE_ZERO            = 16'h0000;
  localparam logic [RATE_W-1:0] IDLE_THROTTLE_DEF    = 16'h0100;  // 16.0
  localparam logic [RATE_W-1:0] ARM_THROTTLE_MAX_DEF = 16'h0020;  //  2.0
  localparam logic [RATE_W-1:0] RAMP_STEP_DEF        = 16'h0010;  //  1.0

  typedef enum logic [2:0] {
    ST_DISARMED  = 3'd0,
    ST_ARM_CHECK = 3'd1,
    ST_SPINUP    = 3'd2,
    ST_ARMED     = 3'd3,
    ST_FAILSAFE  = 3'd4
  } state_t;

endpackage

// File: rtl/motor_arm_controller_throttle_ramp.sv
// throttle_ramp: tick divider plus saturating step toward a target.
//   i_clk, i_reset  clock / synchronous active-high reset
//   i_en            divider runs only while high; held at 0 otherwise
//   i_clr           restart the divider (state entry)
//   i_up            1: step up toward i_target, 0: step down toward it
//   i_target        saturation value
//   i_cur           current throttle value
//   o_tick          one cycle every RAMP_DIV enabled cycles
//   o_next          i_cur stepped by RAMP_STEP, clipped at i_target
module throttle_ramp #(
  parameter int          W         = 16,
  parameter int          RAMP_DIV  = 4,
  parameter logic [W-1:0] RAMP_STEP = 16'h0010
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic         i_up,
  input  logic [W-1:0] i_target,
  input  logic [W-1:0] i_cur,
  output logic         o_tick,
  output logic [W-1:0] o_next
);

  localparam int DW = $clog2(RAMP_DIV + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(RAMP_DIV - 1);

  logic [DW-1:0] r_div;

  assign o_tick = i_en && (r_div == DIV_LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr || !i_en || o_tick) r_div <= '0;
    else                                     r_div <= r_div + 1'b1;
  end

  // One extra bit so the step itself can never wrap; then clip to target.
  logic signed [W:0] w_cur_x, w_tgt_x, w_step_x, w_sum;

  assign w_cur_x  = {i_cur[W-1], i_cur};
  assign w_tgt_x  = {i_target[W-1], i_target};
  assign w_step_x = {RAMP_STEP[W-1], RAMP_STEP};
  assign w_sum    = i_up ? (w_cur_x + w_step_x) : (w_cur_x - w_step_x);

  always_comb begin
    o_next = w_sum[W-1:0];
    if (i_up  && (w_sum > w_tgt_x)) o_next = i_target;
    if (!i_up && (w_sum < w_tgt_x)) o_next = i_target;
  end

endmodule

// File: rtl/motor_arm_controller.sv
// motor_arm_controller: arming / spin-up / failsafe gate between the PID
// rate stage and the motor mixer.
//   sys_clk, reset           clock / synchronous active-high reset
//   arm_req, disarm_req      pilot arm level / kill level
//   rates_valid              one-cycle strobe qualifying the four rates
//   yaw/roll/pitch/throttle_rate   signed 12.4 rates in
//   yaw/roll/pitch/throttle_out    registered signed rates to mixer
//   armed, failsafe          state flags
//   arm_reject               pulse when arming aborts on high throttle
//   state                    current state code
module motor_arm_controller
  import motor_arm_controller_pkg::*;
#(
  parameter int                        RATE_BIT_WIDTH   = RATE_W,
  parameter int                        ARM_HOLD_CYCLES  = 8,
  parameter logic [RATE_BIT_WIDTH-1:0] ARM_THROTTLE_MAX = ARM_THROTTLE_MAX_DEF,
  parameter logic [RATE_BIT_WIDTH-1:0] IDLE_THROTTLE    = IDLE_THROTTLE_DEF,
  parameter logic [RATE_BIT_WIDTH-1:0] RAMP_STEP        = RAMP_STEP_DEF,
  parameter int                        RAMP_DIV         = 4,
  parameter int                        TIMEOUT_CYCLES   = 64
) (
  input  logic                      sys_clk,
  input  logic                      reset,
  input  logic                      arm_req,
  input  logic                      disarm_req,
  input  logic                      rates_valid,
  input  logic [RATE_BIT_WIDTH-1:0] yaw_rate,
  input  logic [RATE_BIT_WIDTH-1:0] roll_rate,
  input  logic [RATE_BIT_WIDTH-1:0] pitch_rate,
  input  logic [RATE_BIT_WIDTH-1:0] throttle_rate,
  output logic [RATE_BIT_WIDTH-1:0] yaw_out,
  output logic [RATE_BIT_WIDTH-1:0] roll_out,
  output logic [RATE_BIT_WIDTH-1:0] pitch_out,
  output logic [RATE_BIT_WIDTH-1:0] throttle_out,
  output logic                      armed,
  output logic                      failsafe,
  output logic                      arm_reject,
  output logic [2:0]                state
);

  localparam int HW = $clog2(ARM_HOLD_CYCLES + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(ARM_HOLD_CYCLES - 1);
  localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT_CYCLES - 1);

  state_t r_state, w_next;
  logic [HW-1:0] r_hold, w_hold_nxt;
  logic [WW-1:0] r_wd, w_wd_nxt;
  logic r_reject, w_reject_nxt;
  logic [RATE_BIT_WIDTH-1:0] r_yaw, r_roll, r_pitch, r_thr;
  logic [RATE_BIT_WIDTH-1:0] w_yaw_nxt, w_roll_nxt, w_pitch_nxt, w_thr_nxt;

  logic w_ramp_en, w_ramp_up, w_ramp_clr, w_tick;
  logic [RATE_BIT_WIDTH-1:0] w_ramp_tgt, w_ramp_next;

  assign w_ramp_clr = (w_next != r_state);

  throttle_ramp #(
    .W(RATE_BIT_WIDTH), .RAMP_DIV(RAMP_DIV), .RAMP_STEP(RAMP_STEP)
  ) u_ramp (
    .i_clk(sys_clk), .i_reset(reset), .i_en(w_ramp_en), .i_clr(w_ramp_clr),
    .i_up(w_ramp_up), .i_target(w_ramp_tgt), .i_cur(r_thr),
    .o_tick(w_tick), .o_next(w_ramp_next)
  );

  always_comb begin
    w_next       = r_state;
    w_hold_nxt   = r_hold;
    w_wd_nxt     = r_wd;
    w_reject_nxt = 1'b0;
    w_yaw_nxt    = r_yaw;
    w_roll_nxt   = r_roll;
    w_pitch_nxt  = r_pitch;
    w_thr_nxt    = r_thr;
    w_ramp_en    = 1'b0;
    w_ramp_up    = 1'b1;
    w_ramp_tgt   = IDLE_THROTTLE;

    if (disarm_req) begin
      w_next      = ST_DISARMED;
      w_hold_nxt  = '0;
      w_wd_nxt    = '0;
      w_yaw_nxt   = RATE_ZERO;
      w_roll_nxt  = RATE_ZERO;
      w_pitch_nxt = RATE_ZERO;
      w_thr_nxt   = RATE_ZERO;
    end else begin
      case (r_state)
        ST_DISARMED, ST_ARM_CHECK: begin
          w_yaw_nxt   = RATE_ZERO;
          w_roll_nxt  = RATE_ZERO;
          w_pitch_nxt = RATE_ZERO;
          w_thr_nxt   = RATE_ZERO;
          w_wd_nxt    = '0;
          if (r_state == ST_DISARMED) begin
            w_hold_nxt = '0;
            if (arm_req) w_next = ST_ARM_CHECK;
          end else if (rates_valid &&
                       ($signed(throttle_rate) > $signed(ARM_THROTTLE_MAX))) begin
            // High-throttle abort takes precedence over a released arm_req.
            w_next       = ST_DISARMED;
            w_reject_nxt = 1'b1;
            w_hold_nxt   = '0;
          end else if (!arm_req) begin
            w_next     = ST_DISARMED;
            w_hold_nxt = '0;
          end else if (r_hold == HOLD_LAST) begin
            w_next     = ST_SPINUP;
            w_hold_nxt = '0;
          end else begin
            w_hold_nxt = r_hold + 1'b1;
          end
        end
        ST_SPINUP: begin
          w_yaw_nxt   = RATE_ZERO;
          w_roll_nxt  = RATE_ZERO;
          w_pitch_nxt = RATE_ZERO;
          w_ramp_en   = 1'b1;
          w_wd_nxt    = '0;  // watchdog starts from zero on ARMED entry
          if (w_tick) w_thr_nxt = w_ramp_next;
          if (r_thr == IDLE_THROTTLE) w_next = ST_ARMED;
        end
        ST_ARMED: begin
          // rates_valid beats the terminal count.
          if (rates_valid) begin
            w_wd_nxt    = '0;
            w_yaw_nxt   = yaw_rate;
            w_roll_nxt  = roll_rate;
            w_pitch_nxt = pitch_rate;
            w_thr_nxt   = throttle_rate[RATE_BIT_WIDTH-1] ? RATE_ZERO : throttle_rate;
          end else if (r_wd == WD_LAST) begin
            w_next      = ST_FAILSAFE;
            w_wd_nxt    = '0;
            w_yaw_nxt   = RATE_ZERO;
            w_roll_nxt  = RATE_ZERO;
            w_pitch_nxt = RATE_ZERO;
          end else begin
            w_wd_nxt = r_wd + 1'b1;
          end
        end
        ST_FAILSAFE: begin
          w_yaw_nxt   = RATE_ZERO;
          w_roll_nxt  = RATE_ZERO;
          w_pitch_nxt = RATE_ZERO;
          w_ramp_en   = 1'b1;
          w_ramp_up   = 1'b0;
          w_ramp_tgt  = RATE_ZERO;
          if (w_tick) w_thr_nxt = w_ramp_next;
          if (r_thr == RATE_ZERO) w_next = ST_DISARMED;
        end
        default: begin  // unused codes fall back to DISARMED
          w_next      = ST_DISARMED;
          w_hold_nxt  = '0;
          w_wd_nxt    = '0;
          w_yaw_nxt   = RATE_ZERO;
          w_roll_nxt  = RATE_ZERO;
          w_pitch_nxt = RATE_ZERO;
          w_thr_nxt   = RATE_ZERO;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_state  <= ST_DISARMED;
      r_hold   <= '0;
      r_wd     <= '0;
      r_reject <= 1'b0;
      r_yaw    <= RATE_ZERO;
      r_roll   <= RATE_ZERO;
      r_pitch  <= RATE_ZERO;
      r_thr    <= RATE_ZERO;
    end else begin
      r_state  <= w_next;
      r_hold   <= w_hold_nxt;
      r_wd     <= w_wd_nxt;
      r_reject <= w_reject_nxt;
      r_yaw    <= w_yaw_nxt;
      r_roll   <= w_roll_nxt;
      r_pitch  <= w_pitch_nxt;
      r_thr    <= w_thr_nxt;
    end
  end

  assign yaw_out      = r_yaw;
  assign roll_out     = r_roll;
  assign pitch_out    = r_pitch;
  assign throttle_out = r_thr;
  assign arm_reject   = r_reject;
  assign armed        = (r_state == ST_ARMED);
  assign failsafe     = (r_state == ST_FAILSAFE);
  assign state        = r_state;

endmodule

// File: tb/tb_motor_arm_controller.sv
// Directed bench for motor_arm_controller. Inputs change 1 time unit after
// the rising edge; outputs are checked at that same point, i.e. they show
// the result of the edge just taken.
module tb_motor_arm_controller;

  logic        sys_clk = 1'b0;
  logic        reset, arm_req, disarm_req, rates_valid;
  logic [15:0] yaw_rate, roll_rate, pitch_rate, throttle_rate;
  logic [15:0] yaw_out, roll_out, pitch_out, throttle_out;
  logic        armed, failsafe, arm_reject;
  logic [2:0]  state;

  int n_cmp = 0;
  int n_err = 0;

  always #5 sys_clk = ~sys_clk;

  motor_arm_controller dut (
    .sys_clk(sys_clk), .reset(reset), .arm_req(arm_req), .disarm_req(disarm_req),
    .rates_valid(rates_valid), .yaw_rate(yaw_rate), .roll_rate(roll_rate),
    .pitch_rate(pitch_rate), .throttle_rate(throttle_rate),
    .yaw_out(yaw_out), .roll_out(roll_out), .pitch_out(pitch_out),
    .throttle_out(throttle_out), .armed(armed), .failsafe(failsafe),
    .arm_reject(arm_reject), .state(state)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; arm_req = 1'b0; disarm_req = 1'b0; rates_valid = 1'b0;
    yaw_rate = 16'h0; roll_rate = 16'h0; pitch_rate = 16'h0; throttle_rate = 16'h0;

    // Reset state
    step(2);
    chk("rst_state", state, 0);
    chk("rst_thr", throttle_out, 0);
    chk("rst_yaw", yaw_out, 0);
    chk("rst_flags", {armed, failsafe, arm_reject}, 0);
    reset = 1'b0;

    // Arm OK: DISARMED->ARM_CHECK on first arm_req edge, then 8 ARM_CHECK cycles
    arm_req = 1'b1;
    step(1);
    chk("arm_chk_entry", state, 1);
    rates_valid = 1'b1; throttle_rate = 16'h0010;  // low throttle: accepted
    step(1);
    rates_valid = 1'b0;
    chk("arm_low_thr_state", state, 1);
    chk("arm_low_thr_rej", arm_reject, 0);
    step(6);
    chk("arm_hold7", state, 1);
    step(1);
    chk("spinup_entry", state, 2);
    chk("spinup_thr0", throttle_out, 16'h0000);
    step(3);
    chk("spinup_pre_tick", throttle_out, 16'h0000);
    step(1);
    chk("spinup_tick1", throttle_out, 16'h0010);
    step(4);
    chk("spinup_tick2", throttle_out, 16'h0020);
    chk("spinup_att0", yaw_out, 16'h0000);
    step(56);
    chk("spinup_idle_thr", throttle_out, 16'h0100);
    chk("spinup_idle_state", state, 2);
    step(1);
    chk("armed_entry", state, 3);
    chk("armed_flag", armed, 1);
    chk("armed_thr", throttle_out, 16'h0100);
    arm_req = 1'b0;

    // Pass-through and negative throttle clamp
    rates_valid = 1'b1;
    yaw_rate = 16'hFFF0; roll_rate = 16'h0123; pitch_rate = 16'h8000; throttle_rate = 16'hFF00;
    step(1);
    chk("pt_yaw", yaw_out, 16'hFFF0);
    chk("pt_roll", roll_out, 16'h0123);
    chk("pt_pitch", pitch_out, 16'h8000);
    chk("pt_thr_clamp", throttle_out, 16'h0000);
    yaw_rate = 16'h0050; roll_rate = 16'hFF80; pitch_rate = 16'h7FFF; throttle_rate = 16'h0200;
    step(1);  // last rates_valid edge (R)
    chk("pt2_yaw", yaw_out, 16'h0050);
    chk("pt2_thr", throttle_out, 16'h0200);
    rates_valid = 1'b0;
    yaw_rate = 16'h1111; throttle_rate = 16'h0777;
    step(3);
    chk("hold_yaw", yaw_out, 16'h0050);
    chk("hold_thr", throttle_out, 16'h0200);

    // Timeout: 64 edges after R without rates_valid -> FAILSAFE
    step(60);
    chk("wd_edge63_state", state, 3);
    step(1);
    chk("fs_entry", state, 4);
    chk("fs_flags", {armed, failsafe}, 2'b01);
    chk("fs_yaw0", yaw_out, 0);
    chk("fs_roll0", roll_out, 0);
    chk("fs_pitch0", pitch_out, 0);
    chk("fs_thr_hold", throttle_out, 16'h0200);
    step(4);
    chk("fs_tick1", throttle_out, 16'h01F0);
    rates_valid = 1'b1; yaw_rate = 16'h0300; throttle_rate = 16'h0300;
    step(1);
    rates_valid = 1'b0;
    chk("fs_rv_state", state, 4);
    chk("fs_rv_yaw", yaw_out, 0);
    chk("fs_rv_thr", throttle_out, 16'h01F0);
    step(122);
    chk("fs_tick31", throttle_out, 16'h0010);
    step(1);
    chk("fs_tick32", throttle_out, 16'h0000);
    chk("fs_at0_state", state, 4);
    step(1);
    chk("fs_exit", state, 0);
    chk("fs_exit_flag", failsafe, 0);

    // Kill mid-SPINUP with arm_req still high
    arm_req = 1'b1; throttle_rate = 16'h0000;
    step(1);
    step(8);
    chk("kill_spinup", state, 2);
    step(8);
    chk("kill_pre_thr", throttle_out, 16'h0020);
    disarm_req = 1'b1;
    step(1);
    chk("kill_state", state, 0);
    chk("kill_thr", throttle_out, 0);
    step(1);
    chk("kill_vs_arm", state, 0);
    disarm_req = 1'b0; arm_req = 1'b0;

    // Arm reject on high throttle
    arm_req = 1'b1;
    step(1);
    chk("rej_chk", state, 1);
    rates_valid = 1'b1; throttle_rate = 16'h0040;
    step(1);
    rates_valid = 1'b0; arm_req = 1'b0;
    chk("rej_pulse", arm_reject, 1);
    chk("rej_state", state, 0);
    chk("rej_thr", throttle_out, 0);
    step(1);
    chk("rej_pulse_end", arm_reject, 0);

    // Boundary: throttle exactly ARM_THROTTLE_MAX is accepted
    arm_req = 1'b1;
    step(1);
    rates_valid = 1'b1; throttle_rate = 16'h0020;
    step(1);
    rates_valid = 1'b0;
    chk("bnd_state", state, 1);
    chk("bnd_rej", arm_reject, 0);
    step(7);
    chk("bnd_spinup", state, 2);
    step(64);
    chk("bnd_idle", throttle_out, 16'h0100);
    step(1);
    chk("bnd_armed", state, 3);
    arm_req = 1'b0;

    // Reset while ARMED with nonzero outputs
    rates_valid = 1'b1; yaw_rate = 16'h0444; throttle_rate = 16'h0180;
    step(1);
    rates_valid = 1'b0;
    chk("pre_rst_yaw", yaw_out, 16'h0444);
    reset = 1'b1;
    step(1);
    chk("mid_rst_state", state, 0);
    chk("mid_rst_yaw", yaw_out, 0);
    chk("mid_rst_thr", throttle_out, 0);
    chk("mid_rst_flags", {armed, failsafe, arm_reject}, 0);
    reset = 1'b0;
    step(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
